// File: rtl/handshake_constant_burst.sv
// Constant/ramp burst source: every accepted ctrl token emits REPEAT tokens
// through a registered, elastic valid/ready output stage.
module handshake_constant_burst #(
    parameter int              DATA_WIDTH  = 32,
    parameter longint unsigned CONST_VALUE = 0,
    parameter int              REPEAT      = 1,
    parameter int              MODE        = 0,
    parameter longint unsigned STRIDE      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);
    localparam int CW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [DATA_WIDTH-1:0] CONST_V  = DATA_WIDTH'(CONST_VALUE);
    localparam logic [DATA_WIDTH-1:0] STRIDE_V = DATA_WIDTH'(STRIDE);
    localparam logic [CW-1:0]         LAST_CNT = CW'(REPEAT - 1);

    // Encoding chosen so bit 0 is the registered valid and bit 1 the registered last.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        LAST = 2'b11
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [DATA_WIDTH-1:0] data, data_d;
    logic                  ctrl_fire, out_fire;

    assign outs_valid = state[0];
    assign outs_last  = state[1];
    assign outs       = data;

    // A new burst may load in the same cycle the final beat drains.
    assign ctrl_ready = !rst && (!outs_valid || (outs_ready && outs_last));
    assign ctrl_fire  = ctrl_valid && ctrl_ready;
    assign out_fire   = outs_valid && outs_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            data  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            data  <= data_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        data_d  = data;
        if (ctrl_fire) begin
            data_d  = CONST_V;
            cnt_d   = '0;
            state_d = (REPEAT == 1) ? LAST : EMIT;
        end else if (out_fire) begin
            case (state)
                EMIT: begin
                    cnt_d = cnt + CW'(1);
                    if (MODE == 1) data_d = data + STRIDE_V;
                    state_d = (cnt_d == LAST_CNT) ? LAST : EMIT;
                end
                // data holds after the burst; downstream ignores it while invalid
                LAST:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_constant_burst.sv
// Runs four configurations side by side against a token-index reference model:
// directed plan steps followed by randomized handshakes and resets.
module tb_handshake_constant_burst;
    localparam int              PW [4] = '{12, 8, 8, 8};
    localparam longint unsigned PC [4] = '{64'hE4E, 64'd10, 64'hFE, 64'h5A};
    localparam int              PR [4] = '{1, 4, 3, 2};
    localparam int              PM [4] = '{0, 1, 1, 0};
    localparam longint unsigned PS [4] = '{64'd1, 64'd3, 64'd1, 64'd1};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cv, orr;
    wire  [3:0] cr, ov, ol;
    wire  [31:0] od [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        handshake_constant_burst #(
            .DATA_WIDTH(PW[g]), .CONST_VALUE(PC[g]), .REPEAT(PR[g]),
            .MODE(PM[g]), .STRIDE(PS[g])
        ) u_dut (
            .clk(clk), .rst(rst),
            .ctrl_valid(cv[g]), .ctrl_ready(cr[g]),
            .outs(od[g][PW[g]-1:0]), .outs_valid(ov[g]),
            .outs_ready(orr[g]), .outs_last(ol[g])
        );
        assign od[g][31:PW[g]] = '0;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: a burst is "active" with token index k; token k = C + k*S mod 2^W.
    bit              act [4];
    int              k   [4];
    longint unsigned mout[4];

    function automatic longint unsigned val(int i, int kk);
        longint unsigned mask = (64'd1 << PW[i]) - 64'd1;
        if (PM[i] == 1) return (PC[i] + longint'(kk) * PS[i]) & mask;
        return PC[i] & mask;
    endfunction

    function automatic bit exp_last(int i);
        return act[i] && (k[i] == PR[i] - 1);
    endfunction

    function automatic bit exp_rdy(int i);
        return !rst && (!act[i] || (orr[i] && exp_last(i)));
    endfunction

    task automatic chk(string tag, int i, longint unsigned obs, longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit rdy [4];
        bit lst [4];
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("outs_valid", i, ov[i], act[i]);
            chk("outs_last", i, ol[i], exp_last(i));
            chk("outs", i, od[i], mout[i]);
            chk("ctrl_ready", i, cr[i], exp_rdy(i));
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rdy[i] = exp_rdy(i);
            lst[i] = exp_last(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                act[i] = 0; k[i] = 0; mout[i] = 0;
            end else if (cv[i] && rdy[i]) begin
                act[i] = 1; k[i] = 0; mout[i] = val(i, 0);
            end else if (act[i] && orr[i]) begin
                if (lst[i]) act[i] = 0;
                else begin
                    k[i]++;
                    mout[i] = val(i, k[i]);
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            act[i] = 0; k[i] = 0; mout[i] = 0;
        end
        // Reset with ctrl_valid high: nothing may be taken.
        rst = 1'b1; cv = 4'hF; orr = 4'hF;
        step(); step();
        // Back-to-back constant tokens and continuous bursts, incl. REPEAT=2 overlap.
        rst = 1'b0;
        repeat (5) step();
        repeat (4) step();
        // Drain.
        cv = 4'h0;
        repeat (6) step();
        // Ramp burst with backpressure while 13 is presented.
        cv = 4'h2; step();
        cv = 4'h0; step();
        orr = 4'hD;
        repeat (3) step();
        orr = 4'hF;
        repeat (4) step();
        // Wrap-around burst on the FE ramp.
        cv = 4'h4; step();
        cv = 4'h0;
        repeat (4) step();
        // Reset mid-burst after two beats, then a fresh token.
        cv = 4'h2; step();
        cv = 4'h0;
        repeat (2) step();
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (2) step();
        cv = 4'h2; step();
        cv = 4'h0;
        repeat (5) step();
        // Randomized handshakes with occasional reset.
        repeat (600) begin
            rst = ($urandom_range(0, 49) == 0);
            cv  = 4'($urandom);
            orr = 4'($urandom | $urandom);
            step();
        end
        rst = 1'b0; cv = 4'h0; orr = 4'hF;
        repeat (6) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
